// File: rtl/cmd_resp_receiver_pkg.sv
// Shared definitions for the SD CMD response receiver: FSM states, frame
// lengths and the CRC7 coverage window.
package cmd_resp_receiver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_RECEIVE,
        ST_CHECK,
        ST_HOLD
    } rx_state_t;

    localparam int R_SHORT_LEN = 48;
    localparam int R_LONG_LEN  = 136;

    localparam logic [6:0] CRC7_POLY = 7'h09;

    // CRC coverage as frame-bit positions, position 0 being the end bit
    localparam int CRC_SHORT_HI = 47;
    localparam int CRC_LONG_HI  = 127;
    localparam int CRC_LO       = 8;

endpackage

// File: rtl/cmd_resp_receiver_if.sv
// Controller-side bundle of the CMD response receiver: arm/config inputs,
// serial pin, and the strobe/ack result handshake.
interface cmd_resp_receiver_if
    import cmd_resp_receiver_pkg::*;
#(
    parameter int LONG_BITS = R_LONG_LEN,
    parameter int TMO_W     = 8
);
    logic                 start;
    logic                 long_resp;
    logic                 crc_en;
    logic [TMO_W-1:0]     timeout_cycles;
    logic                 cmd_pin;
    logic                 ack_in;
    logic [LONG_BITS-1:0] response;
    logic                 strobe_out;
    logic                 busy;
    logic                 timeout_err;
    logic                 crc_err;
    logic                 frame_err;

    modport master (
        output start, long_resp, crc_en, timeout_cycles, cmd_pin, ack_in,
        input  response, strobe_out, busy, timeout_err, crc_err, frame_err
    );

    modport slave (
        input  start, long_resp, crc_en, timeout_cycles, cmd_pin, ack_in,
        output response, strobe_out, busy, timeout_err, crc_err, frame_err
    );
endinterface

// File: rtl/cmd_resp_receiver_crc7.sv
// Bit-serial CRC7 (x^7 + x^3 + 1); shared with the command transmit path.
module crc7_serial
    import cmd_resp_receiver_pkg::*;
(
    input  logic       sd_clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    output logic [6:0] crc
);
    logic fb;

    assign fb = crc[6] ^ bit_in;

    always_ff @(posedge sd_clock or posedge reset) begin
        if (reset)
            crc <= '0;
        else if (clear)
            crc <= '0;
        else if (enable)
            crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
endmodule

// File: rtl/cmd_resp_receiver.sv
// SD CMD-line response receiver: waits for the start bit, shifts in a short or
// long frame, checks CRC7 and framing, then holds the result until acked.
module cmd_resp_receiver
    import cmd_resp_receiver_pkg::*;
#(
    parameter int LONG_BITS  = R_LONG_LEN,
    parameter int SHORT_BITS = R_SHORT_LEN,
    parameter int TMO_W      = 8
) (
    input  logic               sd_clock,
    input  logic               reset,
    cmd_resp_receiver_if.slave bus
);
    localparam int CW       = $clog2(LONG_BITS + 1);
    localparam int SHORT_HI = SHORT_BITS - (R_SHORT_LEN - CRC_SHORT_HI);
    localparam int LONG_HI  = LONG_BITS - (R_LONG_LEN - CRC_LONG_HI);

    rx_state_t        state;
    logic             long_q;
    logic             crc_en_q;
    logic [TMO_W-1:0] tmo_q;
    logic [TMO_W-1:0] wait_cnt;
    logic [TMO_W-1:0] wait_inc;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    n_bits;
    logic [CW-1:0]    pos;
    logic [CW-1:0]    txb_idx;
    logic [6:0]       crc;
    logic             crc_clr;
    logic             crc_upd;
    logic             crc_cov;

    assign n_bits  = long_q ? CW'(LONG_BITS) : CW'(SHORT_BITS);
    assign txb_idx = n_bits - CW'(2);
    // Frame position of the bit being sampled this cycle in RECEIVE
    assign pos     = n_bits - bit_cnt - CW'(1);
    assign crc_cov = (pos >= CW'(CRC_LO)) &&
                     (pos <= (long_q ? CW'(LONG_HI) : CW'(SHORT_HI)));

    // The start bit is a 0 into a cleared register, so clearing on it is
    // equivalent to feeding it through the CRC.
    assign crc_clr = ((state == ST_IDLE) && bus.start) ||
                     ((state == ST_WAIT_START) && !bus.cmd_pin);
    assign crc_upd = (state == ST_RECEIVE) && (bit_cnt != n_bits) && crc_cov;

    assign wait_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + TMO_W'(1);

    crc7_serial u_crc (
        .sd_clock (sd_clock),
        .reset    (reset),
        .clear    (crc_clr),
        .enable   (crc_upd),
        .bit_in   (bus.cmd_pin),
        .crc      (crc)
    );

    always_ff @(posedge sd_clock or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            long_q          <= 1'b0;
            crc_en_q        <= 1'b0;
            tmo_q           <= '0;
            wait_cnt        <= '0;
            bit_cnt         <= '0;
            bus.response    <= '0;
            bus.strobe_out  <= 1'b0;
            bus.busy        <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.crc_err     <= 1'b0;
            bus.frame_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        long_q          <= bus.long_resp;
                        crc_en_q        <= bus.crc_en;
                        tmo_q           <= bus.timeout_cycles;
                        wait_cnt        <= '0;
                        bit_cnt         <= '0;
                        bus.response    <= '0;
                        bus.timeout_err <= 1'b0;
                        bus.crc_err     <= 1'b0;
                        bus.frame_err   <= 1'b0;
                        bus.busy        <= 1'b1;
                        state           <= ST_WAIT_START;
                    end
                end
                ST_WAIT_START: begin
                    // A start bit in the expiry cycle takes priority
                    if (!bus.cmd_pin) begin
                        bus.response <= {bus.response[LONG_BITS-2:0], 1'b0};
                        bit_cnt      <= CW'(1);
                        state        <= ST_RECEIVE;
                    end else begin
                        wait_cnt <= wait_inc;
                        if ((tmo_q != '0) && (wait_inc == tmo_q)) begin
                            bus.timeout_err <= 1'b1;
                            bus.strobe_out  <= 1'b1;
                            state           <= ST_HOLD;
                        end
                    end
                end
                ST_RECEIVE: begin
                    if (bit_cnt == n_bits) begin
                        state <= ST_CHECK;
                    end else begin
                        bus.response <= {bus.response[LONG_BITS-2:0], bus.cmd_pin};
                        bit_cnt      <= bit_cnt + CW'(1);
                    end
                end
                ST_CHECK: begin
                    bus.crc_err    <= crc_en_q && (crc != bus.response[7:1]);
                    bus.frame_err  <= !bus.response[0] || bus.response[txb_idx];
                    bus.strobe_out <= 1'b1;
                    state          <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.ack_in) begin
                        bus.strobe_out <= 1'b0;
                        bus.busy       <= 1'b0;
                        state          <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cmd_resp_receiver.sv
// Scoreboard bench for cmd_resp_receiver: frames built with a reference CRC7,
// expected results queued at arm time and popped when strobe_out rises.
module tb_cmd_resp_receiver;
    localparam int LB = 136;
    localparam int TW = 8;

    logic sd_clock = 1'b0;
    logic reset    = 1'b1;
    int   checks   = 0;
    int   passed   = 0;

    typedef struct {
        logic [LB-1:0] resp;
        logic          tmo;
        logic          crc;
        logic          frm;
    } exp_t;
    exp_t sb[$];

    cmd_resp_receiver_if #(.LONG_BITS(LB), .TMO_W(TW)) bus();

    cmd_resp_receiver #(.LONG_BITS(LB), .SHORT_BITS(48), .TMO_W(TW)) dut (
        .sd_clock (sd_clock),
        .reset    (reset),
        .bus      (bus)
    );

    logic [LB+4:0] outs;
    assign outs = {bus.response, bus.strobe_out, bus.busy,
                   bus.timeout_err, bus.crc_err, bus.frame_err};

    always #5 sd_clock = ~sd_clock;

    task automatic tick();
        @(posedge sd_clock);
        #1;
    endtask

    function automatic logic [6:0] crc7_model(input logic [LB-1:0] f, input int hi);
        logic [6:0] c = '0;
        logic       fb;
        for (int p = hi; p >= 8; p--) begin
            fb = c[6] ^ f[p];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    function automatic logic [LB-1:0] short_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [LB-1:0] f = '0;
        f[47:0] = {1'b0, 1'b0, idx, arg, 7'h00, 1'b1};
        f[7:1]  = crc7_model(f, 47);
        return f;
    endfunction

    function automatic logic [LB-1:0] long_frame();
        logic [LB-1:0] f;
        f      = {1'b0, 1'b0, 6'h3F, {15{8'hA5}}, 7'h00, 1'b1};
        f[7:1] = crc7_model(f, 127);
        return f;
    endfunction

    // Arm on one edge, then scramble the config inputs to prove they were latched
    task automatic arm(input int n, input logic ce, input int tmo);
        bus.cmd_pin        = 1'b1;
        bus.start          = 1'b1;
        bus.long_resp      = (n == LB);
        bus.crc_en         = ce;
        bus.timeout_cycles = TW'(tmo);
        tick();
        bus.start          = 1'b0;
        bus.long_resp      = ~bus.long_resp;
        bus.crc_en         = ~ce;
        bus.timeout_cycles = 8'd1;
    endtask

    task automatic shift_frame(input logic [LB-1:0] f, input int n, input int idle, input int glitch);
        bus.cmd_pin = 1'b1;
        repeat (idle) tick();
        for (int i = 0; i < n; i++) begin
            bus.cmd_pin = f[n-1-i];
            if (i == glitch) begin
                bus.start  = 1'b1;
                bus.ack_in = 1'b1;
            end
            tick();
            bus.start  = 1'b0;
            bus.ack_in = 1'b0;
        end
        bus.cmd_pin = 1'b1;
    endtask

    task automatic await_strobe(output int lat);
        lat = 0;
        while (bus.strobe_out !== 1'b1 && lat < 300) begin
            tick();
            lat++;
        end
        if (bus.strobe_out !== 1'b1) lat = -1;
    endtask

    task automatic do_ack();
        bus.ack_in = 1'b1;
        tick();
        bus.ack_in = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if (outs !== '0) $display("FAIL reset_outputs: got %h want 0", outs);
        else passed++;
        reset = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", bus.busy);
        else passed++;
    endtask

    task automatic test_short_good();
        logic [LB-1:0] f;
        exp_t          e;
        int            lat;
        f = short_frame(6'd7, 32'd789);
        sb.push_back('{f, 1'b0, 1'b0, 1'b0});
        arm(48, 1'b1, 64);
        checks++;
        if (bus.busy !== 1'b1) $display("FAIL short_busy_rise: got %b want 1", bus.busy);
        else passed++;
        shift_frame(f, 48, 5, -1);
        await_strobe(lat);
        // total 48 bits + 2 = 50 edges after the start bit was driven
        checks++;
        if (lat !== 2) $display("FAIL short_latency: got %0d want 2", lat);
        else passed++;
        e = sb.pop_front();
        checks++;
        if ({bus.response, bus.timeout_err, bus.crc_err, bus.frame_err} !== {e.resp, e.tmo, e.crc, e.frm})
            $display("FAIL short_resp: got %h/%b%b%b want %h/%b%b%b", bus.response,
                     bus.timeout_err, bus.crc_err, bus.frame_err, e.resp, e.tmo, e.crc, e.frm);
        else passed++;
        repeat (3) tick();
        checks++;
        if ({bus.strobe_out, bus.response} !== {1'b1, e.resp})
            $display("FAIL short_hold: got %b/%h want 1/%h", bus.strobe_out, bus.response, e.resp);
        else passed++;
        do_ack();
        checks++;
        if ({bus.strobe_out, bus.busy} !== 2'b00)
            $display("FAIL short_ack: got %b%b want 00", bus.strobe_out, bus.busy);
        else passed++;
    endtask

    task automatic test_long();
        logic [LB-1:0] f;
        exp_t          e;
        int            lat;
        f = long_frame();
        for (int k = 0; k < 2; k++) begin
            if (k == 1) f[60] = ~f[60];
            sb.push_back('{f, 1'b0, k == 1, 1'b0});
            arm(LB, 1'b1, 64);
            shift_frame(f, LB, 3, -1);
            await_strobe(lat);
            checks++;
            if (lat !== 2) $display("FAIL long_latency_%0d: got %0d want 2", k, lat);
            else passed++;
            e = sb.pop_front();
            checks++;
            if ({bus.response, bus.timeout_err, bus.crc_err, bus.frame_err} !== {e.resp, e.tmo, e.crc, e.frm})
                $display("FAIL long_resp_%0d: got %h/%b%b%b want %h/%b%b%b", k, bus.response,
                         bus.timeout_err, bus.crc_err, bus.frame_err, e.resp, e.tmo, e.crc, e.frm);
            else passed++;
            do_ack();
        end
    endtask

    task automatic test_timeout();
        logic [LB-1:0] f;
        exp_t          e;
        int            lat;
        int            bad;
        sb.push_back('{'0, 1'b1, 1'b0, 1'b0});
        arm(48, 1'b1, 10);
        await_strobe(lat);
        checks++;
        if (lat !== 10) $display("FAIL timeout_edge: got %0d want 10", lat);
        else passed++;
        e = sb.pop_front();
        checks++;
        if ({bus.response, bus.timeout_err, bus.crc_err, bus.frame_err} !== {e.resp, e.tmo, e.crc, e.frm})
            $display("FAIL timeout_resp: got %h/%b%b%b want %h/%b%b%b", bus.response,
                     bus.timeout_err, bus.crc_err, bus.frame_err, e.resp, e.tmo, e.crc, e.frm);
        else passed++;
        do_ack();

        // start bit lands on the expiry edge: the frame must win
        f = short_frame(6'd2, 32'h0BAD_F00D);
        sb.push_back('{f, 1'b0, 1'b0, 1'b0});
        arm(48, 1'b1, 4);
        shift_frame(f, 48, 3, -1);
        await_strobe(lat);
        e = sb.pop_front();
        checks++;
        if ({bus.response, bus.timeout_err, bus.crc_err, bus.frame_err} !== {e.resp, e.tmo, e.crc, e.frm})
            $display("FAIL start_wins: got %h/%b%b%b want %h/%b%b%b", bus.response,
                     bus.timeout_err, bus.crc_err, bus.frame_err, e.resp, e.tmo, e.crc, e.frm);
        else passed++;
        do_ack();

        arm(48, 1'b1, 0);
        bad = 0;
        repeat (500) begin
            tick();
            if (bus.busy !== 1'b1 || bus.strobe_out !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) $display("FAIL no_timeout: got %0d bad cycles want 0", bad);
        else passed++;
        f = short_frame(6'd17, 32'hDEAD_BEEF);
        sb.push_back('{f, 1'b0, 1'b0, 1'b0});
        shift_frame(f, 48, 0, -1);
        await_strobe(lat);
        e = sb.pop_front();
        checks++;
        if ({bus.response, bus.timeout_err, bus.crc_err, bus.frame_err} !== {e.resp, e.tmo, e.crc, e.frm})
            $display("FAIL after_saturate: got %h/%b%b%b want %h/%b%b%b", bus.response,
                     bus.timeout_err, bus.crc_err, bus.frame_err, e.resp, e.tmo, e.crc, e.frm);
        else passed++;
        do_ack();
    endtask

    task automatic test_framing();
        logic [LB-1:0] fr[4];
        logic          ce[4];
        logic [2:0]    fl[4];
        exp_t          e;
        int            lat;
        fr[0] = short_frame(6'd7, 32'd789); fr[0][0] = 1'b0;            ce[0] = 1'b1; fl[0] = 3'b001;
        fr[1] = short_frame(6'd7, 32'd789); fr[1][46] = 1'b1;
        fr[1][7:1] = crc7_model(fr[1], 47);                              ce[1] = 1'b1; fl[1] = 3'b001;
        fr[2] = short_frame(6'd9, 32'h1234_5678); fr[2][7:1] ^= 7'h55;   ce[2] = 1'b0; fl[2] = 3'b000;
        fr[3] = fr[2];                                                   ce[3] = 1'b1; fl[3] = 3'b010;
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{fr[k], fl[k][2], fl[k][1], fl[k][0]});
            arm(48, ce[k], 64);
            shift_frame(fr[k], 48, 1 + k, -1);
            await_strobe(lat);
            e = sb.pop_front();
            checks++;
            if ({bus.response, bus.timeout_err, bus.crc_err, bus.frame_err} !== {e.resp, e.tmo, e.crc, e.frm})
                $display("FAIL framing_%0d: got %h/%b%b%b want %h/%b%b%b", k, bus.response,
                         bus.timeout_err, bus.crc_err, bus.frame_err, e.resp, e.tmo, e.crc, e.frm);
            else passed++;
            do_ack();
        end
    endtask

    task automatic test_handshake();
        logic [LB-1:0] f;
        exp_t          e;
        int            lat;
        f = short_frame(6'd3, 32'h0000_1234);
        sb.push_back('{f, 1'b0, 1'b0, 1'b0});
        arm(48, 1'b1, 64);
        shift_frame(f, 48, 2, 10);
        await_strobe(lat);
        e = sb.pop_front();
        checks++;
        if (lat !== 2 || {bus.response, bus.timeout_err, bus.crc_err, bus.frame_err} !== {e.resp, e.tmo, e.crc, e.frm})
            $display("FAIL start_in_receive: got %0d/%h want 2/%h", lat, bus.response, e.resp);
        else passed++;
        bus.start   = 1'b1;
        bus.ack_in  = 1'b1;
        bus.cmd_pin = 1'b0;
        tick();
        bus.start  = 1'b0;
        bus.ack_in = 1'b0;
        checks++;
        if ({bus.strobe_out, bus.busy} !== 2'b00)
            $display("FAIL start_ack_hold: got %b%b want 00", bus.strobe_out, bus.busy);
        else passed++;
        repeat (3) tick();
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL no_rearm: got %b want 0", bus.busy);
        else passed++;
        bus.cmd_pin = 1'b1;
    endtask

    task automatic test_reset_corners();
        logic [LB-1:0] f;
        logic [LB-1:0] part;
        int            lat;
        int            strobes;
        arm(48, 1'b1, 3);
        await_strobe(lat);
        checks++;
        if ({bus.strobe_out, bus.timeout_err} !== 2'b11)
            $display("FAIL pre_reset_hold: got %b%b want 11", bus.strobe_out, bus.timeout_err);
        else passed++;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (outs !== '0) $display("FAIL reset_in_hold: got %h want 0", outs);
        else passed++;
        reset = 1'b0;
        tick();

        f = short_frame(6'd7, 32'd789);
        arm(48, 1'b1, 64);
        for (int i = 0; i < 20; i++) begin
            bus.cmd_pin = f[47-i];
            tick();
        end
        part = f >> 28;
        checks++;
        if (bus.response !== part) $display("FAIL partial_resp: got %h want %h", bus.response, part);
        else passed++;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (outs !== '0) $display("FAIL reset_mid_frame: got %h want 0", outs);
        else passed++;
        reset = 1'b0;
        strobes = 0;
        for (int i = 20; i < 48 + 40; i++) begin
            bus.cmd_pin = (i < 48) ? f[47-i] : 1'b1;
            tick();
            if (bus.strobe_out !== 1'b0) strobes++;
        end
        checks++;
        if (strobes !== 0) $display("FAIL strobe_after_abort: got %0d want 0", strobes);
        else passed++;
    endtask

    initial begin
        bus.start          = 1'b0;
        bus.long_resp      = 1'b0;
        bus.crc_en         = 1'b0;
        bus.timeout_cycles = '0;
        bus.cmd_pin        = 1'b1;
        bus.ack_in         = 1'b0;
        test_reset();
        test_short_good();
        test_long();
        test_timeout();
        test_framing();
        test_handshake();
        test_reset_corners();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
